// File: rtl/id_stage.sv
// rtl/id_stage.sv - instruction decode stage with load-use/flag interlock, branch redirect and halt
module id_stage #(
  parameter int WIDTH  = 16,
  parameter int NREG   = 16,
  parameter int BOFF_W = 9,
  parameter int JOFF_W = 12,
  localparam int RA    = $clog2(NREG)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] instr,
  input  logic [WIDTH-1:0] pc,
  input  logic             zr,
  input  logic             ne,
  input  logic             ov,
  input  logic             flag_busy,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [RA-1:0]    p0_addr,
  output logic [RA-1:0]    p1_addr,
  output logic [RA-1:0]    dst_addr,
  output logic             re0,
  output logic             re1,
  output logic             we,
  output logic             memre,
  output logic             memwe,
  output logic             memtoreg,
  output logic             alu_op,
  output logic             src1sel,
  output logic             jal,
  output logic             jr,
  output logic             hlt,
  output logic [2:0]       func,
  output logic [3:0]       shamt,
  output logic [WIDTH-1:0] imm,
  output logic             redirect,
  output logic [WIDTH-1:0] redirect_addr,
  output logic             halted,
  output logic [WIDTH-1:0] stall_cnt
);

  typedef enum logic [1:0] {RUN = 2'd0, SQUASH = 2'd1, HALT = 2'd2} state_t;
  state_t state;

  logic [3:0]       op;
  logic [2:0]       d_func;
  logic [RA-1:0]    d_p0, d_p1, d_dst;
  logic             d_we, d_hlt, d_rd, d_is_b, d_cond, d_taken;
  logic [WIDTH-1:0] boff_sx, joff_sx, d_target;
  logic             load_use, flag_haz, accept;

  assign op      = instr[15:12];
  assign d_is_b  = (op == 4'b1100);
  assign d_hlt   = (op == 4'b1111);
  assign d_rd    = ~d_hlt;
  assign d_p0    = (op == 4'b1010) ? instr[8 +: RA] : instr[4 +: RA];
  assign d_p1    = (op[3:1] == 3'b011 || op == 4'b0101) ? instr[4 +: RA] : instr[0 +: RA];
  assign d_we    = ~op[3] | (op == 4'b1000) | (op == 4'b1010) | (op == 4'b1011) | (op == 4'b1101);
  assign boff_sx = {{(WIDTH-BOFF_W){instr[BOFF_W-1]}}, instr[BOFF_W-1:0]};
  assign joff_sx = {{(WIDTH-JOFF_W){instr[JOFF_W-1]}}, instr[JOFF_W-1:0]};
  assign d_target = pc + (d_is_b ? boff_sx : joff_sx);
  assign d_taken = (d_is_b & d_cond) | (op == 4'b1101);

  always_comb begin
    d_func = 3'b000;
    case (op)
      4'b0001, 4'b1000, 4'b1001: d_func = 3'b000;
      4'b1010:                   d_func = 3'b001;
      4'b1011, 4'b1100:          d_func = 3'b111;
      default:                   if (!op[3]) d_func = instr[14:12];
    endcase
  end

  // ADDZ only writes its destination when the zero flag is set; otherwise it targets R0
  always_comb begin
    d_dst = instr[8 +: RA];
    if (op == 4'b1101)      d_dst = RA'(NREG - 1);
    else if (d_is_b)        d_dst = '0;
    else if (op == 4'b0001) d_dst = zr ? instr[8 +: RA] : '0;
  end

  always_comb begin
    d_cond = 1'b0;
    case (instr[11:9])
      3'b000: d_cond = ~zr;
      3'b001: d_cond = zr;
      3'b010: d_cond = ~(zr | ne);
      3'b011: d_cond = ne;
      3'b100: d_cond = ~ne;
      3'b101: d_cond = ne | zr;
      3'b110: d_cond = ov;
      3'b111: d_cond = 1'b1;
    endcase
  end

  assign load_use = out_valid & memtoreg & (dst_addr != '0) &
                    (((dst_addr == d_p0) & d_rd) | ((dst_addr == d_p1) & d_rd));
  assign flag_haz = flag_busy & d_is_b & (instr[11:9] != 3'b111);
  assign in_ready = (state == SQUASH) |
                    ((state == RUN) & (~out_valid | out_ready) & ~flush & ~load_use & ~flag_haz);
  assign accept   = in_valid & in_ready & (state == RUN);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
      out_valid <= 1'b0; redirect <= 1'b0; halted <= 1'b0;
      redirect_addr <= '0; stall_cnt <= '0;
      p0_addr <= '0; p1_addr <= '0; dst_addr <= '0;
      re0 <= 1'b0; re1 <= 1'b0; we <= 1'b0; memre <= 1'b0; memwe <= 1'b0;
      memtoreg <= 1'b0; alu_op <= 1'b0; src1sel <= 1'b0;
      jal <= 1'b0; jr <= 1'b0; hlt <= 1'b0;
      func <= '0; shamt <= '0; imm <= '0;
    end else begin
      if (state == RUN && in_valid && !in_ready && stall_cnt != '1)
        stall_cnt <= stall_cnt + 1'b1;
      if (flush) begin
        out_valid <= 1'b0;
        redirect  <= 1'b0;
        if (state != HALT) state <= RUN;
      end else if (accept) begin
        out_valid <= 1'b1;
        p0_addr <= d_p0; p1_addr <= d_p1; dst_addr <= d_dst;
        re0 <= d_rd; re1 <= d_rd; memre <= d_rd;
        we <= d_we; memwe <= (op == 4'b1001); memtoreg <= (op == 4'b1000);
        alu_op <= ~op[3]; src1sel <= op[3];
        jal <= (op == 4'b1101); jr <= (op == 4'b1110); hlt <= d_hlt;
        func <= d_func;
        shamt <= op[3] ? 4'd8 : instr[3:0];
        imm <= {{(WIDTH-8){instr[7]}}, instr[7:0]};
        redirect <= d_taken;
        if (d_taken) redirect_addr <= d_target;
        if (d_hlt) begin
          state  <= HALT;
          halted <= 1'b1;
        end else begin
          state <= d_taken ? SQUASH : RUN;
        end
      end else begin
        redirect <= 1'b0;
        if (out_ready) out_valid <= 1'b0;
        case (state)
          RUN, HALT: state <= state;
          default:   state <= RUN;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_id_stage.sv
// tb/tb_id_stage.sv - directed and randomized checks of id_stage against a transaction-level model
module tb_id_stage;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, zr, ne, ov, flag_busy, flush, out_valid, out_ready;
  logic [15:0] instr, pc, imm, redirect_addr, stall_cnt;
  logic [3:0]  p0_addr, p1_addr, dst_addr, shamt;
  logic        re0, re1, we, memre, memwe, memtoreg, alu_op, src1sel, jal, jr, hlt;
  logic [2:0]  func;
  logic        redirect, halted;

  always #5 clk = ~clk;

  id_stage dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .instr(instr), .pc(pc),
    .zr(zr), .ne(ne), .ov(ov), .flag_busy(flag_busy), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .p0_addr(p0_addr), .p1_addr(p1_addr), .dst_addr(dst_addr),
    .re0(re0), .re1(re1), .we(we), .memre(memre), .memwe(memwe), .memtoreg(memtoreg),
    .alu_op(alu_op), .src1sel(src1sel), .jal(jal), .jr(jr), .hlt(hlt),
    .func(func), .shamt(shamt), .imm(imm),
    .redirect(redirect), .redirect_addr(redirect_addr), .halted(halted), .stall_cnt(stall_cnt)
  );

  typedef struct packed {
    logic [3:0] p0, p1, dst;
    logic re0, re1, we, memre, memwe, memtoreg, alu_op, src1sel, jal, jr, hlt;
    logic [2:0] func;
    logic [3:0] shamt;
    logic [15:0] imm;
  } bundle_t;

  bundle_t dut_b;
  assign dut_b = {p0_addr, p1_addr, dst_addr, re0, re1, we, memre, memwe, memtoreg,
                  alu_op, src1sel, jal, jr, hlt, func, shamt, imm};

  int n_pass = 0;
  int n_total = 0;
  bit last_rdy;

  // model state: 0 = running, 1 = discarding one fetch after a jump, 2 = halted
  int          m_state;
  bit          m_valid, m_redir, m_halted;
  bundle_t     m_b;
  logic [15:0] m_raddr, m_stall;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    assert (got === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic void ref_decode(input logic [15:0] ins, input logic [15:0] npc,
                                     input bit fz, input bit fn, input bit fo,
                                     output bundle_t b, output bit taken,
                                     output logic [15:0] tgt, output bit is_b);
    int op, off, sum;
    bit c;
    op = int'(ins[15:12]);
    is_b = (op == 12);
    b = '0;
    b.p0 = (op == 10) ? ins[11:8] : ins[7:4];
    b.p1 = (op == 6 || op == 7 || op == 5) ? ins[7:4] : ins[3:0];
    if (op == 13)      b.dst = 4'd15;
    else if (op == 12) b.dst = 4'd0;
    else if (op == 1)  b.dst = fz ? ins[11:8] : 4'd0;
    else               b.dst = ins[11:8];
    b.hlt = (op == 15);
    b.re0 = !b.hlt; b.re1 = !b.hlt; b.memre = !b.hlt;
    b.we = (op < 8) || op == 8 || op == 10 || op == 11 || op == 13;
    b.memwe = (op == 9);
    b.memtoreg = (op == 8);
    b.alu_op = (op < 8);
    b.src1sel = (op >= 8);
    b.jal = (op == 13);
    b.jr = (op == 14);
    if (op == 1 || op == 8 || op == 9) b.func = 3'd0;
    else if (op == 10)                 b.func = 3'd1;
    else if (op == 11 || op == 12)     b.func = 3'd7;
    else if (op < 8)                   b.func = ins[14:12];
    else                               b.func = 3'd0;
    b.shamt = (op < 8) ? ins[3:0] : 4'd8;
    b.imm = 16'($signed(ins[7:0]));
    case (ins[11:9])
      3'd0: c = !fz;
      3'd1: c = fz;
      3'd2: c = !fz && !fn;
      3'd3: c = fn;
      3'd4: c = !fn;
      3'd5: c = fn || fz;
      3'd6: c = fo;
      default: c = 1;
    endcase
    if (op == 12) off = ins[8] ? int'(ins[8:0]) - 512 : int'(ins[8:0]);
    else          off = ins[11] ? int'(ins[11:0]) - 4096 : int'(ins[11:0]);
    sum = (int'(npc) + off) % 65536;
    if (sum < 0) sum += 65536;
    tgt = 16'(sum);
    taken = (op == 13) || (op == 12 && c);
  endfunction

  task automatic step();
    bundle_t d;
    bit tk, isb, haz, rdy, acc;
    logic [15:0] tg;
    #4;
    ref_decode(instr, pc, zr, ne, ov, d, tk, tg, isb);
    haz = (m_valid && m_b.memtoreg && m_b.dst != 0 &&
           ((m_b.dst == d.p0 && d.re0) || (m_b.dst == d.p1 && d.re1))) ||
          (flag_busy && isb && instr[11:9] != 3'b111);
    if (m_state == 1)      rdy = 1;
    else if (m_state == 0) rdy = !flush && (!m_valid || out_ready) && !haz;
    else                   rdy = 0;
    last_rdy = in_ready;
    check("in_ready", in_ready, rdy);
    acc = in_valid && rdy && m_state == 0;
    @(posedge clk);
    if (rst) begin
      m_state = 0; m_valid = 0; m_redir = 0; m_halted = 0;
      m_b = '0; m_raddr = 0; m_stall = 0;
    end else begin
      if (m_state == 0 && in_valid && !rdy && m_stall != 16'hFFFF) m_stall = m_stall + 1;
      if (flush) begin
        m_valid = 0; m_redir = 0;
        if (m_state != 2) m_state = 0;
      end else if (acc) begin
        m_b = d; m_valid = 1; m_redir = tk;
        if (tk) m_raddr = tg;
        if (d.hlt) begin m_state = 2; m_halted = 1; end
        else m_state = tk ? 1 : 0;
      end else begin
        m_redir = 0;
        if (out_ready) m_valid = 0;
        if (m_state == 1) m_state = 0;
      end
    end
    #1;
    check("out_valid", out_valid, m_valid);
    check("redirect", redirect, m_redir);
    check("redirect_addr", redirect_addr, m_raddr);
    check("halted", halted, m_halted);
    check("stall_cnt", stall_cnt, m_stall);
    check("bundle", dut_b, m_b);
  endtask

  initial begin
    rst = 1; in_valid = 0; instr = 0; pc = 0; zr = 0; ne = 0; ov = 0;
    flag_busy = 0; flush = 0; out_ready = 1;
    m_state = 0; m_valid = 0; m_redir = 0; m_halted = 0; m_b = '0; m_raddr = 0; m_stall = 0;
    @(posedge clk); #1;
    step();
    check("reset_valid", out_valid, 0);
    rst = 0;

    // ADD R3,R1,R2
    in_valid = 1; instr = 16'h0312; pc = 16'h0001;
    step();
    check("add_valid", out_valid, 1);
    check("add_p0", p0_addr, 1);
    check("add_p1", p1_addr, 2);
    check("add_dst", dst_addr, 3);
    check("add_we", we, 1);
    check("add_func", func, 0);

    // load-use interlock
    rst = 1; in_valid = 0; step(); rst = 0;
    in_valid = 1; instr = 16'h8410;
    step();
    check("lw_memtoreg", memtoreg, 1);
    instr = 16'h0541;
    step();
    check("lu_stall_rdy", last_rdy, 0);
    check("lu_bubble", out_valid, 0);
    step();
    check("lu_issue_rdy", last_rdy, 1);
    check("lu_issue_dst", dst_addr, 5);
    check("lu_stall_cnt", stall_cnt, 1);

    // taken BEQ backwards, then squashed fetch
    zr = 1; instr = 16'hC3FE; pc = 16'h0040;
    step();
    check("beq_redirect", redirect, 1);
    check("beq_target", redirect_addr, 16'h003E);
    instr = 16'h0312; pc = 16'h003F;
    step();
    check("squash_redirect", redirect, 0);
    check("squash_valid", out_valid, 0);
    step();
    check("after_squash_dst", dst_addr, 3);

    // ADDZ destination depends on zero flag
    zr = 0; instr = 16'h1612;
    step();
    check("addz_nz_dst", dst_addr, 0);
    zr = 1;
    step();
    check("addz_z_dst", dst_addr, 6);

    // flush beats a JAL in the same cycle
    flush = 1; instr = 16'hD010;
    step();
    check("flush_redirect", redirect, 0);
    check("flush_valid", out_valid, 0);
    flush = 0;

    // HLT holds until reset
    instr = 16'hF000;
    step();
    check("hlt_halted", halted, 1);
    check("hlt_bit", hlt, 1);
    check("hlt_we", we, 0);
    instr = 16'h0312;
    for (int i = 0; i < 5; i++) begin
      step();
      check("halt_rdy", last_rdy, 0);
      check("halt_hold", halted, 1);
    end
    rst = 1; step(); rst = 0;
    check("halt_cleared", halted, 0);
    step();
    check("post_rst_rdy", last_rdy, 1);

    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 99) == 0) || (m_state == 2 && $urandom_range(0, 7) == 0);
      in_valid = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      flush = ($urandom_range(0, 15) == 0);
      flag_busy = ($urandom_range(0, 3) == 0);
      zr = 1'($urandom); ne = 1'($urandom); ov = 1'($urandom);
      pc = 16'($urandom);
      instr = 16'($urandom);
      if (instr[15:12] == 4'hF && $urandom_range(0, 29) != 0) instr[15:12] = 4'h0;
      if ($urandom_range(0, 1) == 1) instr[11:0] = instr[11:0] & 12'h333;
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
